alu_sequencer: RTL and testbench

Execute-stage wrapper that feeds operands to the 32-bit combinational ALU and registers its result and flags behind a valid/ready handshake. It adds a multi-cycle unsigned multiply (MUL) built from 32 iterations of the ALU ADD operation. It sits between instruction decode/operand fetch upstream and write-back downstream.

---
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - execute-stage ALU wrapper with registered results and shift-add MUL
module alu_sequencer #(
   parameter int WIDTH     = 32,
   parameter int MUL_ITERS = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carryout,
   output logic             out_zero,
   output logic             out_overflow,
   output logic             out_illegal,
   output logic             busy
);

   localparam int CW = $clog2(MUL_ITERS);
   localparam logic [CW-1:0] LAST_ITER = CW'(MUL_ITERS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic             lost, ovf;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] alu_a, alu_b, alu_res, b_eff;
   logic [2:0]       alu_ctl;
   logic [WIDTH:0]   sum_ext;
   logic             alu_cout, alu_ovf, add_ovf, sub;

   logic [WIDTH-1:0] mul_acc_nxt;
   logic             mul_ovf_nxt;
   logic             accept;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_MUL);
   assign accept    = in_valid && (state == S_IDLE);

   // Operand mux: live inputs while idle, accumulator/multiplicand while multiplying.
   always_comb begin
      alu_a   = acc;
      alu_b   = mcand;
      alu_ctl = 3'd0;
      if (state == S_IDLE) begin
         alu_a   = in_a;
         alu_b   = in_b;
         alu_ctl = in_op[2:0];
      end
   end

   // Combinational ALU; SUB and SLT share the adder via b inversion and carry-in.
   always_comb begin
      sub      = (alu_ctl == 3'd1) || (alu_ctl == 3'd3);
      b_eff    = sub ? ~alu_b : alu_b;
      sum_ext  = {1'b0, alu_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      add_ovf  = (alu_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != alu_a[WIDTH-1]);
      alu_res  = '0;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
      case (alu_ctl)
         3'd0, 3'd1: begin
            alu_res  = sum_ext[WIDTH-1:0];
            alu_cout = sum_ext[WIDTH];
            alu_ovf  = add_ovf;
         end
         3'd2: alu_res = alu_a ^ alu_b;
         3'd3: alu_res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ add_ovf};
         3'd4: alu_res = alu_a & alu_b;
         3'd5: alu_res = ~(alu_a & alu_b);
         3'd6: alu_res = ~(alu_a | alu_b);
         default: alu_res = alu_a | alu_b;
      endcase
   end

   // Multiply step: a set multiplier bit adds the shifted multiplicand; any carry out
   // or previously shifted-off multiplicand bit means the product exceeds WIDTH bits.
   always_comb begin
      mul_acc_nxt = mplier[0] ? alu_res : acc;
      mul_ovf_nxt = ovf | (mplier[0] & (alu_cout | lost));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (in_valid) state_nxt = (in_op == 4'd8) ? S_MUL : S_DONE;
         S_MUL:  if (cnt == LAST_ITER) state_nxt = S_DONE;
         default: if (out_ready) state_nxt = S_IDLE;
      endcase
   end

   // Datapath: result/flag registers and multiply working registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         lost         <= 1'b0;
         ovf          <= 1'b0;
         cnt          <= '0;
         out_result   <= '0;
         out_carryout <= 1'b0;
         out_zero     <= 1'b0;
         out_overflow <= 1'b0;
         out_illegal  <= 1'b0;
      end else if (accept) begin
         out_illegal <= 1'b0;
         if (!in_op[3]) begin
            out_result   <= alu_res;
            out_carryout <= alu_cout;
            out_zero     <= (alu_res == '0);
            out_overflow <= alu_ovf;
         end else if (in_op == 4'd8) begin
            acc    <= '0;
            mcand  <= in_a;
            mplier <= in_b;
            lost   <= 1'b0;
            ovf    <= 1'b0;
            cnt    <= '0;
         end else begin
            out_result   <= '0;
            out_carryout <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b1;
         end
      end else if (state == S_MUL) begin
         acc    <= mul_acc_nxt;
         ovf    <= mul_ovf_nxt;
         lost   <= lost | mcand[WIDTH-1];
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (cnt == LAST_ITER) begin
            out_result   <= mul_acc_nxt;
            out_carryout <= 1'b0;
            out_zero     <= (mul_acc_nxt == '0);
            out_overflow <= mul_ovf_nxt;
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = 4'd0;
   logic [31:0] in_a = 32'd0;
   logic [31:0] in_b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_carryout, out_zero, out_overflow, out_illegal, busy;

   int vectors = 0;
   int miscompares = 0;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   alu_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_carryout(out_carryout), .out_zero(out_zero), .out_overflow(out_overflow),
      .out_illegal(out_illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: {result, carryout, zero, overflow, illegal} from arithmetic definitions.
   function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        c, v, il;
      longint      sa, sb, s;
      logic [63:0] p;
      logic [32:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = 32'd0; c = 1'b0; v = 1'b0; il = 1'b0;
      case (op)
         4'd0: begin u = {1'b0, a} + {1'b0, b}; r = u[31:0]; c = u[32]; s = sa + sb; v = (s > SMAX) || (s < SMIN); end
         4'd1: begin r = a - b; c = (a >= b); s = sa - sb; v = (s > SMAX) || (s < SMIN); end
         4'd2: r = a ^ b;
         4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd4: r = a & b;
         4'd5: r = ~(a & b);
         4'd6: r = ~(a | b);
         4'd7: r = a | b;
         4'd8: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; v = (p[63:32] != 32'd0); end
         default: il = 1'b1;
      endcase
      return {r, c, (!il && r == 32'd0), v, il};
   endfunction

   function automatic logic [35:0] outs();
      return {out_result, out_carryout, out_zero, out_overflow, out_illegal};
   endfunction

   // Present one request, then wait (bounded) for out_valid; lat counts edges after accept.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cycles);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      @(negedge clk);
      in_valid = 1'b0; in_op = 4'($urandom); in_a = $urandom; in_b = $urandom;
      lat = 0; busy_cycles = 0;
      while (!out_valid && lat < 60) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({outs(), out_valid, busy, in_ready} !== {36'd0, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset: got outs=%h v=%b busy=%b rdy=%b, want all 0 with in_ready=1",
                  outs(), out_valid, busy, in_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_alu_directed();
      int lat, bc;
      logic [3:0]  ops [3] = '{4'd0, 4'd1, 4'd3};
      logic [31:0] as  [3] = '{32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF};
      logic [31:0] bs  [3] = '{32'h7FFFFFFF, 32'h12345678, 32'h7FFFFFFF};
      logic [35:0] exp [3] = '{{32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0},
                               {32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0},
                               {32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0}};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], as[i], bs[i], lat, bc);
         vectors++;
         if (lat !== 0 || outs() !== exp[i]) begin
            miscompares++;
            $display("FAIL alu_directed[%0d]: got lat=%0d outs=%h, want lat=0 outs=%h", i, lat, outs(), exp[i]);
         end
         release_result();
         vectors++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_return_idle[%0d]: got rdy=%b v=%b, want rdy=1 v=0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_mul_directed();
      int lat, bc;
      logic [31:0] as [3] = '{32'h00003039, 32'h00010000, 32'hFFFFFFFF};
      logic [31:0] bs [3] = '{32'h0000D431, 32'h00010000, 32'h00000001};
      logic [35:0] exp [3] = '{{32'h27F86EE9, 1'b0, 1'b0, 1'b0, 1'b0},
                               {32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0},
                               {32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
      for (int i = 0; i < 3; i++) begin
         issue(4'd8, as[i], bs[i], lat, bc);
         vectors++;
         if (lat !== 32 || bc !== 32 || outs() !== exp[i]) begin
            miscompares++;
            $display("FAIL mul_directed[%0d]: got lat=%0d busy=%0d outs=%h, want lat=32 busy=32 outs=%h",
                     i, lat, bc, outs(), exp[i]);
         end
         release_result();
      end
   endtask

   task automatic test_backpressure();
      int lat, bc;
      issue(4'd0, 32'd1, 32'd2, lat, bc);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i == 2); in_op = 4'd2; in_a = 32'hA5A5A5A5; in_b = 32'h0F0F0F0F;
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || outs() !== {32'd3, 4'b0000}) begin
            miscompares++;
            $display("FAIL backpressure_hold[%0d]: got v=%b rdy=%b outs=%h, want v=1 rdy=0 outs=%h",
                     i, out_valid, in_ready, outs(), {32'd3, 4'b0000});
         end
      end
      in_valid = 1'b0;
      release_result();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd3) begin
         miscompares++;
         $display("FAIL backpressure_release: got v=%b rdy=%b res=%h, want v=0 rdy=1 res=00000003",
                  out_valid, in_ready, out_result);
      end
   endtask

   task automatic test_reset_mid_mul();
      int lat, bc;
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd8; in_a = 32'hDEADBEEF; in_b = 32'hFFFFFFFF;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({outs(), out_valid, busy, in_ready} !== {36'd0, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_mid_mul: got outs=%h v=%b busy=%b rdy=%b, want all 0 with in_ready=1",
                  outs(), out_valid, busy, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(4'd0, 32'd5, 32'hFFFFFFFB, lat, bc);
      vectors++;
      if (lat !== 0 || outs() !== {32'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL add_after_reset: got lat=%0d outs=%h, want lat=0 outs=%h", lat, outs(),
                  {32'd0, 1'b1, 1'b1, 1'b0, 1'b0});
      end
      release_result();
      issue(4'hC, 32'hFFFFFFFF, 32'h12345678, lat, bc);
      vectors++;
      if (lat !== 0 || outs() !== {32'd0, 4'b0001}) begin
         miscompares++;
         $display("FAIL illegal_op: got lat=%0d outs=%h, want lat=0 outs=%h", lat, outs(), {32'd0, 4'b0001});
      end
      release_result();
   endtask

   task automatic test_random_ops(input int n, input bit mul_only);
      int lat, bc, exp_lat;
      logic [3:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < n; i++) begin
         op = mul_only ? 4'd8 : 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 3))
            0: begin a = a >> $urandom_range(0, 31); b = b >> $urandom_range(0, 31); end
            1: b = a;
            default: ;
         endcase
         issue(op, a, b, lat, bc);
         exp_lat = (op == 4'd8) ? 32 : 0;
         vectors++;
         if (lat !== exp_lat || outs() !== model(op, a, b)) begin
            miscompares++;
            $display("FAIL random op=%0d a=%h b=%h: got lat=%0d outs=%h, want lat=%0d outs=%h",
                     op, a, b, lat, outs(), exp_lat, model(op, a, b));
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_alu_directed();
      test_mul_directed();
      test_backpressure();
      test_reset_mid_mul();
      test_random_ops(60, 1'b0);
      test_random_ops(12, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
